// File: rtl/ro_puf_response_sequencer_if.sv
// rtl/ro_puf_response_sequencer_if.sv - request and RO-PUF array signals of the response sequencer
// master is the sequencer side; slave is the host/PUF side.
interface ro_puf_response_sequencer_if #(
  parameter int NUM_BITS = 8
);
  logic                start;
  logic [7:0]          challenge;
  logic                puf_in;
  logic [3:0]          select1;
  logic [3:0]          select2;
  logic                ro_enable;
  logic                ro_reset;
  logic                busy;
  logic                done;
  logic [NUM_BITS-1:0] response;

  modport master (
    input  start, challenge, puf_in,
    output select1, select2, ro_enable, ro_reset, busy, done, response
  );

  modport slave (
    output start, challenge, puf_in,
    input  select1, select2, ro_enable, ro_reset, busy, done, response
  );
endinterface

// File: rtl/ro_puf_response_sequencer.sv
// rtl/ro_puf_response_sequencer.sv - per-bit RO pair select, clear, measure, settle and capture sequencer
// Builds a NUM_BITS response from one challenge, one RO pair comparison per bit.
module ro_puf_response_sequencer #(
  parameter int NUM_BITS   = 8,
  parameter int WINDOW     = 4096,
  parameter int RST_CYCLES = 2,
  parameter int SETTLE     = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  ro_puf_response_sequencer_if.master   bus
);

  localparam int IW   = $clog2(NUM_BITS) + 1;
  localparam int MAXC = (WINDOW > RST_CYCLES) ?
                        ((WINDOW > SETTLE) ? WINDOW : SETTLE) :
                        ((RST_CYCLES > SETTLE) ? RST_CYCLES : SETTLE);
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CLEAR, S_MEASURE, S_SETTLE, S_SAMPLE, S_NEXT
  } state_t;

  state_t              state, next_state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [1:0]          sync;
  logic [3:0]          sel1, sel2;
  logic [NUM_BITS-1:0] resp;
  logic [NUM_BITS-1:0] mask;
  logic                last_bit;
  logic                same_pair;

  assign last_bit  = (idx == IW'(NUM_BITS - 1));
  assign mask      = NUM_BITS'(1) << idx;
  assign same_pair = (sel1 == sel2);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    bus.ro_enable = 1'b0;
    bus.ro_reset  = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    case (state)
      S_IDLE: begin
        bus.ro_reset = 1'b1;
        bus.busy     = 1'b0;
        if (bus.start) next_state = S_SETUP;
      end
      S_SETUP:   next_state = same_pair ? S_NEXT : S_CLEAR;
      S_CLEAR: begin
        bus.ro_reset = 1'b1;
        if (cnt == CW'(RST_CYCLES - 1)) next_state = S_MEASURE;
      end
      S_MEASURE: begin
        bus.ro_enable = 1'b1;
        if (cnt == CW'(WINDOW - 1)) next_state = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt == CW'(SETTLE - 1)) next_state = S_SAMPLE;
      end
      S_SAMPLE:  next_state = S_NEXT;
      S_NEXT: begin
        if (last_bit) begin
          bus.done   = 1'b1;
          next_state = S_IDLE;
        end else begin
          next_state = S_SETUP;
        end
      end
      default:   next_state = S_IDLE;
    endcase
  end

  // Selects advance only on NEXT->SETUP, so they never move while the ROs run.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= '0;
      idx  <= '0;
      sync <= '0;
      sel1 <= '0;
      sel2 <= '0;
      resp <= '0;
    end else begin
      sync <= {sync[0], bus.puf_in};
      if (next_state != state) begin
        cnt <= '0;
      end else if (state == S_CLEAR || state == S_MEASURE || state == S_SETTLE) begin
        cnt <= cnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            sel1 <= bus.challenge[3:0];
            sel2 <= bus.challenge[7:4];
            idx  <= '0;
            resp <= '0;
          end
        end
        S_SETUP: begin
          if (same_pair) resp <= resp & ~mask;
        end
        S_SAMPLE: resp <= sync[1] ? (resp | mask) : (resp & ~mask);
        S_NEXT: begin
          if (!last_bit) begin
            idx  <= idx + 1'b1;
            sel1 <= sel1 + 4'd1;
            sel2 <= sel2 + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.select1  = sel1;
  assign bus.select2  = sel2;
  assign bus.response = resp;

endmodule
